// File: rtl/tone_monitor.sv
// ---------------------------------------------------------------------------
// tone_monitor
//
// Windowed statistics engine for a differential tone presented as two
// single-ended legs in microvolts. Each accepted window of 2^WINDOW_LOG2
// samples produces three results:
//   - amplitude : (max(diff) - min(diff)) / 4, the single-ended peak amplitude
//   - common mode: mean of (p + n) / 2 over the window
//   - zero crossings: rising differential crossings, with hysteresis
//
// Ports
//   clk           in   1   clock, all state updates on the rising edge
//   reset_n       in   1   asynchronous active-low reset
//   en            in   1   acquisition enable
//   sample_valid  in   1   qualifies sig_p_uv / sig_n_uv
//   sig_p_uv      in  32   signed positive-leg voltage (uV)
//   sig_n_uv      in  32   signed negative-leg voltage (uV)
//   result_valid  out  1   one-cycle pulse, new results on the outputs
//   ampl_uv       out 32   signed amplitude estimate (uV)
//   vcm_uv        out 32   signed window-mean common mode (uV)
//   zc_count      out WINDOW_LOG2  rising zero crossings in the window
//   busy          out  1   high while acquiring or reporting
//   dropped       out  8   saturating count of samples ignored while reporting
// ---------------------------------------------------------------------------
module tone_monitor #(
    parameter int WINDOW_LOG2 = 8,
    parameter int HYST_UV     = 10000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic                    sample_valid,
    input  logic signed [31:0]      sig_p_uv,
    input  logic signed [31:0]      sig_n_uv,
    output logic                    result_valid,
    output logic signed [31:0]      ampl_uv,
    output logic signed [31:0]      vcm_uv,
    output logic [WINDOW_LOG2-1:0]  zc_count,
    output logic                    busy,
    output logic [7:0]              dropped
);

    // Accumulator holds the sum of up to 2^WINDOW_LOG2 33-bit values.
    localparam int ACC_W = 33 + WINDOW_LOG2;

    localparam logic [WINDOW_LOG2-1:0] LAST_IDX = '1;

    localparam logic signed [32:0] HYST_POS = 33'(HYST_UV);
    localparam logic signed [32:0] HYST_NEG = -HYST_POS;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACQ    = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    // ------------------------------------------------------------------
    // Scaling / saturation helpers
    // ------------------------------------------------------------------

    // Peak-to-peak of diff is 4x the single-ended amplitude; the span of two
    // 33-bit values needs 34 bits before the divide.
    function automatic logic signed [31:0] quarter_span(
        input logic signed [32:0] hi,
        input logic signed [32:0] lo
    );
        logic signed [33:0] span;
        span = 34'(hi) - 34'(lo);
        return 32'(span >>> 2);
    endfunction

    // Mean of (p+n)/2 over N samples is sum / 2N, a shift by WINDOW_LOG2+1.
    function automatic logic signed [31:0] mean_half(
        input logic signed [ACC_W-1:0] acc
    );
        return 32'(acc >>> (WINDOW_LOG2 + 1));
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]                r_state;
    logic [WINDOW_LOG2-1:0]    r_cnt;
    logic signed [32:0]        r_max;
    logic signed [32:0]        r_min;
    logic signed [ACC_W-1:0]   r_acc;
    logic [WINDOW_LOG2-1:0]    r_zc;
    logic                      r_pol;
    logic                      r_rv;
    logic signed [31:0]        r_ampl;
    logic signed [31:0]        r_vcm;
    logic [WINDOW_LOG2-1:0]    r_zc_out;
    logic [7:0]                r_dropped;

    // ------------------------------------------------------------------
    // Per-sample datapath (combinational next values)
    // ------------------------------------------------------------------
    logic signed [32:0]        w_diff;
    logic signed [32:0]        w_sum;
    logic                      w_first;
    logic                      w_last;
    logic                      w_rise;
    logic                      w_fall;
    logic signed [32:0]        w_max_nxt;
    logic signed [32:0]        w_min_nxt;
    logic signed [ACC_W-1:0]   w_acc_nxt;
    logic [WINDOW_LOG2-1:0]    w_zc_nxt;

    assign w_diff = 33'(sig_p_uv) - 33'(sig_n_uv);
    assign w_sum  = 33'(sig_p_uv) + 33'(sig_n_uv);

    assign w_first = (r_cnt == '0);
    assign w_last  = (r_cnt == LAST_IDX);

    // Hysteresis comparator: arm on a strong positive diff, re-arm only
    // after a strong negative diff.
    assign w_rise = !r_pol && (w_diff > HYST_POS);
    assign w_fall =  r_pol && (w_diff < HYST_NEG);

    // The first sample of a window seeds the extrema and the accumulator,
    // so stale values from an earlier or aborted window never leak in.
    assign w_max_nxt = (w_first || (w_diff > r_max)) ? w_diff : r_max;
    assign w_min_nxt = (w_first || (w_diff < r_min)) ? w_diff : r_min;
    assign w_acc_nxt = w_first ? ACC_W'(w_sum) : (r_acc + ACC_W'(w_sum));

    // Crossing count restarts at window start; the first sample's own
    // crossing still counts.
    assign w_zc_nxt = (w_first ? '0 : r_zc) + WINDOW_LOG2'(w_rise);

    // ------------------------------------------------------------------
    // Control FSM and registered results
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_max     <= '0;
            r_min     <= '0;
            r_acc     <= '0;
            r_zc      <= '0;
            r_pol     <= 1'b0;
            r_rv      <= 1'b0;
            r_ampl    <= '0;
            r_vcm     <= '0;
            r_zc_out  <= '0;
            r_dropped <= '0;
        end else begin
            r_rv <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (en) begin
                        r_state <= S_ACQ;
                    end
                end

                S_ACQ: begin
                    if (!en) begin
                        // Abort: partial window is abandoned, the sample
                        // presented this cycle is not taken.
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (sample_valid) begin
                        r_max <= w_max_nxt;
                        r_min <= w_min_nxt;
                        r_acc <= w_acc_nxt;
                        r_zc  <= w_zc_nxt;
                        r_cnt <= r_cnt + WINDOW_LOG2'(1);
                        if (w_rise) begin
                            r_pol <= 1'b1;
                        end else if (w_fall) begin
                            r_pol <= 1'b0;
                        end
                        // Results are captured from the next-value terms so
                        // they include the final sample and appear during
                        // the single REPORT cycle.
                        if (w_last) begin
                            r_state  <= S_REPORT;
                            r_ampl   <= quarter_span(w_max_nxt, w_min_nxt);
                            r_vcm    <= mean_half(w_acc_nxt);
                            r_zc_out <= w_zc_nxt;
                            r_rv     <= 1'b1;
                        end
                    end
                end

                S_REPORT: begin
                    r_cnt <= '0;
                    if (sample_valid) begin
                        r_dropped <= sat_inc8(r_dropped);
                    end
                    r_state <= en ? S_ACQ : S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign result_valid = r_rv;
    assign ampl_uv      = r_ampl;
    assign vcm_uv       = r_vcm;
    assign zc_count     = r_zc_out;
    assign dropped      = r_dropped;
    assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_tone_monitor.sv
module tb_tone_monitor;

    localparam int L    = 8;
    localparam int N    = 1 << L;
    localparam int HYST = 10000;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                en;
    logic                sample_valid;
    logic signed [31:0]  sig_p_uv;
    logic signed [31:0]  sig_n_uv;
    logic                result_valid;
    logic signed [31:0]  ampl_uv;
    logic signed [31:0]  vcm_uv;
    logic [L-1:0]        zc_count;
    logic                busy;
    logic [7:0]          dropped;

    int checks = 0;
    int errors = 0;

    // Reference state at specification level
    bit m_pol;
    int m_dropped;
    int g_p [N];
    int g_n [N];

    tone_monitor #(.WINDOW_LOG2(L), .HYST_UV(HYST)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en),
        .sample_valid (sample_valid),
        .sig_p_uv     (sig_p_uv),
        .sig_n_uv     (sig_n_uv),
        .result_valid (result_valid),
        .ampl_uv      (ampl_uv),
        .vcm_uv       (vcm_uv),
        .zc_count     (zc_count),
        .busy         (busy),
        .dropped      (dropped)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference: statistics of the first cnt samples of g_p/g_n, with the
    // crossing detector state carried in m_pol.
    task automatic model_window(input int cnt, output logic [31:0] ea,
                                output logic [31:0] ev, output logic [L-1:0] ez);
        longint d, s, mx, mn, acc;
        int zc;
        mx = 0; mn = 0; acc = 0; zc = 0;
        for (int i = 0; i < cnt; i++) begin
            d = longint'(g_p[i]) - longint'(g_n[i]);
            s = longint'(g_p[i]) + longint'(g_n[i]);
            if (i == 0) begin
                mx = d; mn = d; acc = s;
            end else begin
                if (d > mx) mx = d;
                if (d < mn) mn = d;
                acc += s;
            end
            if (!m_pol && d > HYST) begin
                m_pol = 1'b1;
                zc++;
            end else if (m_pol && d < -HYST) begin
                m_pol = 1'b0;
            end
        end
        ea = 32'((mx - mn) >>> 2);
        ev = 32'(acc >>> (L + 1));
        ez = L'(zc);
    endtask

    task automatic start_acq(input bit junk);
        en = 1'b1;
        sample_valid = junk;
        sig_p_uv = $urandom;
        sig_n_uv = $urandom;
        cycle();
        sample_valid = 1'b0;
    endtask

    // Drives g_p/g_n as one window with random idle gaps, records whether
    // result_valid showed up early, and returns what is seen right after the
    // edge that took the last sample.
    task automatic drive_window(input int gap_max, output bit early, output logic rv,
                                output logic [31:0] a, output logic [31:0] v,
                                output logic [L-1:0] z, output logic b);
        int gaps;
        early = 1'b0;
        for (int i = 0; i < N; i++) begin
            gaps = int'($urandom_range(gap_max, 0));
            repeat (gaps) begin
                sample_valid = 1'b0;
                cycle();
                if (result_valid !== 1'b0) early = 1'b1;
            end
            sample_valid = 1'b1;
            sig_p_uv = g_p[i];
            sig_n_uv = g_n[i];
            cycle();
            if (i < N - 1 && result_valid !== 1'b0) early = 1'b1;
        end
        rv = result_valid;
        a  = ampl_uv;
        v  = vcm_uv;
        z  = zc_count;
        b  = busy;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; en = 1'b0; sample_valid = 1'b0;
        sig_p_uv = '0; sig_n_uv = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({result_valid, ampl_uv, vcm_uv, zc_count, dropped, busy} !== '0) begin
            errors++;
            $display("FAIL reset_state got rv=%0b a=%0d v=%0d z=%0d drop=%0d busy=%0b want all 0",
                     result_valid, ampl_uv, vcm_uv, zc_count, dropped, busy);
        end
        reset_n = 1'b1;
        m_pol = 1'b0;
        m_dropped = 0;
        sample_valid = 1'b1;
        cycle();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_en got busy=%0b want 0", busy);
        end
        sample_valid = 1'b0;
    endtask

    task automatic test_square();
        bit early; logic rv, b; logic [31:0] a, v, ea, ev; logic [L-1:0] z, ez;
        for (int w = 0; w < 2; w++) begin
            start_acq(1'b0);
            if (w == 1) begin
                checks++;
                if (result_valid !== 1'b0 || ampl_uv !== 32'sd200000) begin
                    errors++;
                    $display("FAIL square_hold got rv=%0b a=%0d want rv=0 a=200000", result_valid, ampl_uv);
                end
            end
            for (int i = 0; i < N; i++) begin
                g_p[i] = ((i / 8) % 2 == 0) ? 700000 : 300000;
                g_n[i] = ((i / 8) % 2 == 0) ? 300000 : 700000;
            end
            drive_window(w * 2, early, rv, a, v, z, b);
            model_window(N, ea, ev, ez);
            checks++;
            if ({early, rv, b, a, v, z} !== {1'b0, 1'b1, 1'b1, ea, ev, ez}) begin
                errors++;
                $display("FAIL square_w%0d got early=%0b rv=%0b busy=%0b a=%0d v=%0d z=%0d want 0 1 1 a=%0d v=%0d z=%0d",
                         w, early, rv, b, $signed(a), $signed(v), z, $signed(ea), $signed(ev), ez);
            end
            if (w == 0) begin
                checks++;
                if (a !== 32'd200000 || v !== 32'd500000 || z !== L'(16)) begin
                    errors++;
                    $display("FAIL square_const got a=%0d v=%0d z=%0d want 200000 500000 16",
                             $signed(a), $signed(v), z);
                end
            end
            sample_valid = 1'b0;
        end
        en = 1'b0;
        cycle();
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL square_to_idle got busy=%0b rv=%0b want 0 0", busy, result_valid);
        end
    endtask

    task automatic test_dc();
        bit early; logic rv, b; logic [31:0] a, v, ea, ev; logic [L-1:0] z, ez;
        start_acq(1'b0);
        for (int i = 0; i < N; i++) begin
            g_p[i] = 1200000;
            g_n[i] = 600000;
        end
        drive_window(0, early, rv, a, v, z, b);
        model_window(N, ea, ev, ez);
        checks++;
        if ({early, rv, a, v, z} !== {1'b0, 1'b1, 32'd0, 32'd900000, L'(1)} ||
            {a, v, z} !== {ea, ev, ez}) begin
            errors++;
            $display("FAIL dc_window got early=%0b rv=%0b a=%0d v=%0d z=%0d want 0 1 a=0 v=900000 z=1",
                     early, rv, $signed(a), $signed(v), z);
        end
        en = 1'b0; sample_valid = 1'b0;
        cycle();
        checks++;
        if (result_valid !== 1'b0 || vcm_uv !== 32'sd900000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL dc_pulse_hold got rv=%0b v=%0d busy=%0b want 0 900000 0",
                     result_valid, vcm_uv, busy);
        end
    endtask

    task automatic test_hysteresis();
        bit early; logic rv, b; logic [31:0] a, v, ea, ev; logic [L-1:0] z, ez;
        start_acq(1'b0);
        for (int i = 0; i < N; i++) begin
            g_p[i] = 600000 + ((i % 2) ? 2500 : -2500);
            g_n[i] = 600000 - ((i % 2) ? 2500 : -2500);
        end
        drive_window(1, early, rv, a, v, z, b);
        model_window(N, ea, ev, ez);
        checks++;
        if ({early, rv, a, v, z} !== {1'b0, 1'b1, 32'd2500, 32'd600000, L'(0)} ||
            {a, v, z} !== {ea, ev, ez}) begin
            errors++;
            $display("FAIL hyst_small got early=%0b rv=%0b a=%0d v=%0d z=%0d want 0 1 a=2500 v=600000 z=0",
                     early, rv, $signed(a), $signed(v), z);
        end
        en = 1'b0; sample_valid = 1'b0;
        cycle();
    endtask

    // Diffs of exactly +/-HYST must not move the detector; one step beyond
    // each threshold must.
    task automatic test_hyst_edge();
        bit early; logic rv, b; logic [31:0] a, v, ea, ev; logic [L-1:0] z, ez;
        int d;
        start_acq(1'b0);
        for (int i = 0; i < N; i++) begin
            d = (i % 2) ? HYST : -HYST;
            if (i == 100) d = -HYST - 1;
            if (i == 101) d = HYST;
            if (i == 102) d = HYST + 1;
            g_n[i] = 400000;
            g_p[i] = 400000 + d;
        end
        drive_window(0, early, rv, a, v, z, b);
        model_window(N, ea, ev, ez);
        checks++;
        if ({early, rv, a, v, z} !== {1'b0, 1'b1, ea, ev, ez} || z !== L'(1) || a !== 32'd5000) begin
            errors++;
            $display("FAIL hyst_edge got early=%0b rv=%0b a=%0d v=%0d z=%0d want a=5000 v=%0d z=1",
                     early, rv, $signed(a), $signed(v), z, $signed(ev));
        end
        en = 1'b0; sample_valid = 1'b0;
        cycle();
    endtask

    task automatic test_abort();
        bit early, seen; logic rv, b; logic [31:0] a, v, ea, ev; logic [L-1:0] z, ez;
        seen = 1'b0;
        start_acq(1'b1);
        for (int i = 0; i < 100; i++) begin
            g_p[i] = int'($urandom_range(4000000, 0)) - 2000000;
            g_n[i] = int'($urandom_range(4000000, 0)) - 2000000;
            sample_valid = 1'b1;
            sig_p_uv = g_p[i];
            sig_n_uv = g_n[i];
            cycle();
            if (result_valid !== 1'b0) seen = 1'b1;
        end
        model_window(100, ea, ev, ez);
        en = 1'b0;
        sample_valid = 1'b1;
        sig_p_uv = 32'sd5000000;
        sig_n_uv = -32'sd5000000;
        cycle();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got busy=%0b want 0", busy);
        end
        repeat (4) begin
            sample_valid = $urandom;
            cycle();
            if (result_valid !== 1'b0) seen = 1'b1;
        end
        start_acq(1'b0);
        for (int i = 0; i < N; i++) begin
            g_p[i] = int'($urandom_range(4000000, 0)) - 2000000;
            g_n[i] = int'($urandom_range(4000000, 0)) - 2000000;
        end
        drive_window(1, early, rv, a, v, z, b);
        model_window(N, ea, ev, ez);
        checks++;
        if ({seen, early, rv, a, v, z} !== {1'b0, 1'b0, 1'b1, ea, ev, ez}) begin
            errors++;
            $display("FAIL abort_restart got seen=%0b early=%0b rv=%0b a=%0d v=%0d z=%0d want 0 0 1 a=%0d v=%0d z=%0d",
                     seen, early, rv, $signed(a), $signed(v), z, $signed(ea), $signed(ev), ez);
        end
        en = 1'b0; sample_valid = 1'b0;
        cycle();
        checks++;
        if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_single_pulse got rv=%0b want 0", result_valid);
        end
    endtask

    task automatic test_random();
        bit early; logic rv, b; logic [31:0] a, v, ea, ev; logic [L-1:0] z, ez;
        for (int w = 0; w < 2; w++) begin
            start_acq(1'b0);
            for (int i = 0; i < N; i++) begin
                g_p[i] = int'($urandom);
                g_n[i] = int'($urandom);
            end
            g_p[5] = 32'h7fffffff; g_n[5] = 32'h80000000;
            g_p[9] = 32'h80000000; g_n[9] = 32'h7fffffff;
            g_p[13] = 32'h7fffffff; g_n[13] = 32'h7fffffff;
            drive_window(3, early, rv, a, v, z, b);
            model_window(N, ea, ev, ez);
            checks++;
            if ({early, rv, a, v, z} !== {1'b0, 1'b1, ea, ev, ez}) begin
                errors++;
                $display("FAIL random_w%0d got early=%0b rv=%0b a=%0d v=%0d z=%0d want 0 1 a=%0d v=%0d z=%0d",
                         w, early, rv, $signed(a), $signed(v), z, $signed(ea), $signed(ev), ez);
            end
            sample_valid = 1'b0;
        end
        en = 1'b0;
        cycle();
    endtask

    task automatic test_tone();
        bit early; logic rv, b; logic [31:0] a, v, ea, ev; logic [L-1:0] z, ez;
        int s;
        start_acq(1'b0);
        for (int i = 0; i < N; i++) begin
            s = (i % 4 == 1) ? 1 : ((i % 4 == 3) ? -1 : 0);
            g_p[i] = 900000 + 1000000 * s + int'($urandom_range(4000, 0)) - 2000;
            g_n[i] = 900000 - 1000000 * s + int'($urandom_range(4000, 0)) - 2000;
        end
        drive_window(2, early, rv, a, v, z, b);
        model_window(N, ea, ev, ez);
        checks++;
        if ({early, rv, a, v, z} !== {1'b0, 1'b1, ea, ev, ez}) begin
            errors++;
            $display("FAIL tone_model got early=%0b rv=%0b a=%0d v=%0d z=%0d want a=%0d v=%0d z=%0d",
                     early, rv, $signed(a), $signed(v), z, $signed(ea), $signed(ev), ez);
        end
        checks++;
        if ($signed(a) < 990000 || $signed(a) > 1010000 || $signed(v) < 891000 ||
            $signed(v) > 909000 || z < L'(63) || z > L'(65)) begin
            errors++;
            $display("FAIL tone_bounds got a=%0d v=%0d z=%0d want a~1000000 v~900000 z~64",
                     $signed(a), $signed(v), z);
        end
        en = 1'b0; sample_valid = 1'b0;
        cycle();
    endtask

    // Continuous samples across three windows: the sample in each REPORT
    // cycle is discarded and counted.
    task automatic test_back_to_back();
        bit early; logic rv, b; logic [31:0] a, v, ea, ev; logic [L-1:0] z, ez;
        en = 1'b1;
        sample_valid = 1'b1;
        sig_p_uv = 32'sd123456;
        sig_n_uv = -32'sd654321;
        cycle();
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < N; i++) begin
                g_p[i] = int'($urandom_range(3000000, 0)) - 1000000;
                g_n[i] = int'($urandom_range(3000000, 0)) - 1000000;
            end
            drive_window(0, early, rv, a, v, z, b);
            model_window(N, ea, ev, ez);
            checks++;
            if ({early, rv, a, v, z} !== {1'b0, 1'b1, ea, ev, ez}) begin
                errors++;
                $display("FAIL b2b_w%0d got early=%0b rv=%0b a=%0d v=%0d z=%0d want 0 1 a=%0d v=%0d z=%0d",
                         w, early, rv, $signed(a), $signed(v), z, $signed(ea), $signed(ev), ez);
            end
            if (w == 2) begin
                checks++;
                if (dropped !== 8'd2) begin
                    errors++;
                    $display("FAIL b2b_dropped3 got %0d want 2", dropped);
                end
            end
            sample_valid = 1'b1;
            sig_p_uv = int'($urandom);
            sig_n_uv = int'($urandom);
            cycle();
            m_dropped++;
            checks++;
            if (dropped !== 8'(m_dropped) || result_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_drop_w%0d got drop=%0d rv=%0b busy=%0b want drop=%0d rv=0 busy=1",
                         w, dropped, result_valid, busy, m_dropped);
            end
        end
        en = 1'b0; sample_valid = 1'b0;
        cycle();
    endtask

    task automatic test_reset_mid();
        bit early; logic rv, b; logic [31:0] a, v, ea, ev; logic [L-1:0] z, ez;
        start_acq(1'b0);
        for (int i = 0; i < 50; i++) begin
            sample_valid = 1'b1;
            sig_p_uv = int'($urandom_range(2000000, 0));
            sig_n_uv = int'($urandom_range(2000000, 0));
            cycle();
        end
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({result_valid, ampl_uv, vcm_uv, zc_count, dropped, busy} !== '0) begin
            errors++;
            $display("FAIL reset_async got rv=%0b a=%0d v=%0d z=%0d drop=%0d busy=%0b want all 0",
                     result_valid, ampl_uv, vcm_uv, zc_count, dropped, busy);
        end
        en = 1'b0; sample_valid = 1'b0;
        #2 reset_n = 1'b1;
        m_pol = 1'b0;
        m_dropped = 0;
        cycle();
        start_acq(1'b0);
        for (int i = 0; i < N; i++) begin
            g_p[i] = int'($urandom_range(2000000, 0)) - 1000000;
            g_n[i] = int'($urandom_range(2000000, 0)) - 1000000;
        end
        g_p[0] = 500000; g_n[0] = 0;
        drive_window(1, early, rv, a, v, z, b);
        model_window(N, ea, ev, ez);
        checks++;
        if ({early, rv, a, v, z, dropped} !== {1'b0, 1'b1, ea, ev, ez, 8'd0}) begin
            errors++;
            $display("FAIL reset_restart got early=%0b rv=%0b a=%0d v=%0d z=%0d drop=%0d want 0 1 a=%0d v=%0d z=%0d drop=0",
                     early, rv, $signed(a), $signed(v), z, dropped, $signed(ea), $signed(ev), ez);
        end
        en = 1'b0; sample_valid = 1'b0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_square();
        test_dc();
        test_hysteresis();
        test_hyst_edge();
        test_abort();
        test_random();
        test_tone();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
